hilo_muldiv_sequencer: RTL and testbench
========================================

Name: hilo_muldiv_sequencer

Overview:
Iterative multiply/divide sequencer that owns the HI/LO result pair for the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs one shift-add or restoring-division step per cycle. It drives a stall request to the hazard logic, holding PC and IF/ID while a result is pending and an MFHI/MFLO or a new mul/div op wants it. This replaces the single-cycle 64-bit ALU product path into the HI/LO register.

Parameters:
WIDTH, 32, operand width; product and {HI,LO} are 2*WIDTH.

Ports:
Clk  input  1  system clock, all state changes on rising edge
Rst  input  1  synchronous active-high reset
Start  input  1  EX-stage mul/div op valid this cycle
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
OpA  input  WIDTH  rs operand (multiplicand / dividend)
OpB  input  WIDTH  rt operand (multiplier / divisor)
Flush  input  1  cancel in-flight op (branch/exception squash)
HiLoRead  input  1  ID stage holds MFHI/MFLO this cycle
Busy  output  1  op in flight (RUN or FIX)
Stall  output  1  request to deassert PCWrite/IFIDWrite and bubble ID/EX
Done  output  1  one-cycle pulse: Hi/Lo just updated
Hi  output  WIDTH  HI register (product high / remainder)
Lo  output  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset (Rst high at edge): state IDLE, count 0, Hi=0, Lo=0, Busy=0, Done=0, Stall=0. Rst overrides Start and Flush and aborts any op.
- States: IDLE, RUN, FIX, DONE. DONE behaves as IDLE, except that Done=1.
- IDLE/DONE + Start: latch Op. For signed ops latch |OpA|, |OpB| and the signs; for unsigned ops latch the raw values. Clear the accumulator and set count=0.
  - If Op is DIV/DIVU and OpB==0, go to FIX.
  - Otherwise go to RUN.
- RUN, multiply: if multiplier LSB is set, add the multiplicand to the upper half of the 2*WIDTH accumulator (carry kept). Then shift the accumulator right 1.
- RUN, divide: restoring step. Shift {rem,quot} left 1, trial-subtract the divisor from rem. If the result is non-negative, keep it and set quot LSB.
- RUN: count increments each cycle. When count==WIDTH-1, go to FIX.
- FIX (1 cycle), normal case:
  - MULT: negate the 64-bit product when signA^signB.
  - DIV: negate the quotient when signA^signB. Negate the remainder when signA.
  - Hi/Lo are written at the end of FIX, then go to DONE.
- FIX, divide by zero: Lo=all ones, Hi=OpA as latched (unsigned raw / signed original value).
- Latency: Start sampled at edge 0. Hi/Lo are valid and Done=1 after edge WIDTH+1 for normal ops, and after edge 1 for divide by zero. Done lasts exactly 1 cycle.
- Busy = state in {RUN, FIX}.
- Stall = Busy & (HiLoRead | Start), combinational. Hi/Lo are readable in the same cycle Done is high.
- Start while Busy: ignored. Stall keeps the op held upstream, and it is re-presented once Busy drops.
- Start in DONE: accepted like IDLE. Done still pulses for the finished op.
- Flush: return to IDLE next edge with Hi/Lo unchanged and no Done. Flush in IDLE/DONE with Start set discards the Start.
- Arithmetic: signed MIN_INT handling is exact, since magnitudes are taken as WIDTH-bit unsigned. MULT 0x80000000*0x80000000 gives Hi=0x40000000, Lo=0.
- Hi/Lo hold their values between ops and are never partially updated.

Test Plan:
- MULTU OpA=0xFFFFFFFF OpB=2 -> Busy for 33 cycles; Done after edge 33; Hi=0x00000001, Lo=0xFFFFFFFE.
- MULT OpA=-3 (0xFFFFFFFD) OpB=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Then DIV OpA=-7 OpB=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- DIVU OpA=0x1234 OpB=0 -> Done after edge 1; Lo=0xFFFFFFFF, Hi=0x00001234; Busy high only 1 cycle.
- During RUN: HiLoRead=1 -> Stall=1 every busy cycle, Stall=0 in the Done cycle. A second Start held during Busy is accepted only on the Done cycle and produces its own correct result.
- Rst pulsed at RUN count=10 -> next cycle Hi=Lo=0, Busy=0, Done never pulses. Flush at count=10 after a prior result Hi=5, Lo=7 -> IDLE, Hi=5, Lo=7, no Done.
- Back-to-back DIVU 100/7 then MULTU 6*7 with Start asserted in the DONE cycle -> first gives Lo=14, Hi=2; second gives Lo=42, Hi=0, with Done exactly 33 edges later.

Source files
------------

// File: rtl/hilo_muldiv_sequencer.sv
// ============================================================================
// hilo_muldiv_sequencer
//   Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair, with stall.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             Flush,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_is_div;
  logic                 r_divzero;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_raw_a;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_signed;
  logic                 w_divzero;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_trial;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_div_next;
  logic                 w_neg_res;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  assign w_idle    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept  = w_idle && Start && !Flush;
  assign w_signed  = !Op[0];
  assign w_divzero = Op[1] && (OpB == '0);
  // Magnitudes are unsigned WIDTH-bit, so the most negative operand stays exact.
  assign w_mag_a   = (w_signed && OpA[WIDTH-1]) ? (~OpA + 1'b1) : OpA;
  assign w_mag_b   = (w_signed && OpB[WIDTH-1]) ? (~OpB + 1'b1) : OpB;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial    = w_rem_sh - {1'b0, r_b};
  assign w_ge       = !w_trial[WIDTH];
  assign w_div_next = {(w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_ge};

  assign w_neg_res = r_sign_a ^ r_sign_b;
  assign w_prod    = w_neg_res ? (~r_acc + 1'b1) : r_acc;
  assign w_quot    = w_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem     = r_sign_a ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_divzero) begin
      w_fix_hi = r_raw_a;
      w_fix_lo = '1;
    end else if (r_is_div) begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quot;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_next = S_IDLE;
        if (Start) w_next = w_divzero ? S_FIX : S_RUN;
      end
      S_RUN:   if (r_count == c_last) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (Flush) w_next = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_count   <= '0;
      r_is_div  <= 1'b0;
      r_divzero <= 1'b0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_raw_a   <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (w_accept) begin
      r_count   <= '0;
      r_is_div  <= Op[1];
      r_divzero <= w_divzero;
      r_sign_a  <= w_signed && OpA[WIDTH-1];
      r_sign_b  <= w_signed && OpB[WIDTH-1];
      r_a       <= w_mag_a;
      r_b       <= w_mag_b;
      r_raw_a   <= OpA;
      // Dividend rides in the low half; it shifts up into the remainder.
      r_acc     <= Op[1] ? {{WIDTH{1'b0}}, w_mag_a} : '0;
    end else if (r_state == S_RUN && !Flush) begin
      r_count <= r_count + 1'b1;
      if (r_is_div) begin
        r_acc <= w_div_next;
      end else begin
        r_acc <= w_mul_next;
        r_b   <= r_b >> 1;
      end
    end else if (r_state == S_FIX && !Flush) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end
  end

  assign Busy  = (r_state == S_RUN) || (r_state == S_FIX);
  assign Stall = Busy && (HiLoRead || Start);
  assign Done  = (r_state == S_DONE);
  assign Hi    = r_hi;
  assign Lo    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_sequencer.sv
// ============================================================================
// tb_hilo_muldiv_sequencer
//   Directed self-checking bench for hilo_muldiv_sequencer.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_sequencer;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        Flush;
  logic        HiLoRead;
  logic        Busy;
  logic        Stall;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int n_checks = 0;
  int n_pass   = 0;

  hilo_muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Flush(Flush), .HiLoRead(HiLoRead), .Busy(Busy), .Stall(Stall),
    .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = (Busy === 1'b1) ? 1 : 0;
    while (Done !== 1'b1 && edges < 200) begin
      @(negedge Clk);
      edges++;
      if (Busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 1'b1; Op = OP_MULTU; OpA = 32'd3; OpB = 32'd3;
    Flush = 1'b0; HiLoRead = 1'b1;
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({Busy, Done, Stall} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {Busy, Done, Stall});
    else n_pass++;
    n_checks++;
    if (Hi !== 32'h0 || Lo !== 32'h0) $display("FAIL reset_hilo: got %h/%h want 0/0", Hi, Lo);
    else n_pass++;
    Rst = 1'b0; Start = 1'b0; HiLoRead = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_multu();
    int e, b;
    start_op(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_done(e, b);
    n_checks++;
    if (e !== 33 || b !== 33) $display("FAIL multu_latency: got edges %0d busy %0d want 33/33", e, b);
    else n_pass++;
    n_checks++;
    if (Hi !== 32'h1 || Lo !== 32'hFFFFFFFE) $display("FAIL multu_result: got %h/%h want 00000001/fffffffe", Hi, Lo);
    else n_pass++;
    @(negedge Clk);
    n_checks++;
    if (Done !== 1'b0 || Hi !== 32'h1 || Lo !== 32'hFFFFFFFE)
      $display("FAIL done_pulse: got done %b hi %h lo %h want 0/00000001/fffffffe", Done, Hi, Lo);
    else n_pass++;
  endtask

  task automatic test_signed();
    int e, b;
    start_op(OP_MULT, 32'hFFFFFFFD, 32'd5);
    wait_done(e, b);
    n_checks++;
    if (Hi !== 32'hFFFFFFFF || Lo !== 32'hFFFFFFF1) $display("FAIL mult_neg: got %h/%h want ffffffff/fffffff1", Hi, Lo);
    else n_pass++;
    @(negedge Clk);
    start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(e, b);
    n_checks++;
    if (Hi !== 32'hFFFFFFFF || Lo !== 32'hFFFFFFFD) $display("FAIL div_neg: got %h/%h want ffffffff/fffffffd", Hi, Lo);
    else n_pass++;
    @(negedge Clk);
    start_op(OP_MULT, 32'h80000000, 32'h80000000);
    wait_done(e, b);
    n_checks++;
    if (Hi !== 32'h40000000 || Lo !== 32'h0) $display("FAIL mult_minint: got %h/%h want 40000000/00000000", Hi, Lo);
    else n_pass++;
    @(negedge Clk);
  endtask

  task automatic test_divzero();
    int e, b;
    start_op(OP_DIVU, 32'h1234, 32'd0);
    wait_done(e, b);
    n_checks++;
    if (e !== 1 || b !== 1) $display("FAIL divzero_latency: got edges %0d busy %0d want 1/1", e, b);
    else n_pass++;
    n_checks++;
    if (Hi !== 32'h1234 || Lo !== 32'hFFFFFFFF) $display("FAIL divu_zero: got %h/%h want 00001234/ffffffff", Hi, Lo);
    else n_pass++;
    @(negedge Clk);
    start_op(OP_DIV, 32'hFFFFFFFB, 32'd0);
    wait_done(e, b);
    n_checks++;
    if (Hi !== 32'hFFFFFFFB || Lo !== 32'hFFFFFFFF) $display("FAIL div_zero: got %h/%h want fffffffb/ffffffff", Hi, Lo);
    else n_pass++;
    @(negedge Clk);
  endtask

  task automatic test_stall();
    int e, b, bad;
    HiLoRead = 1'b1; Start = 1'b1; Op = OP_MULTU; OpA = 32'd3; OpB = 32'd4;
    @(negedge Clk);
    OpA = 32'd10; OpB = 32'd11;
    e = 0; bad = 0;
    while (Done !== 1'b1 && e < 200) begin
      if (Stall !== 1'b1) bad++;
      @(negedge Clk);
      e++;
    end
    n_checks++;
    if (e !== 33 || bad !== 0) $display("FAIL stall_busy: got edges %0d unstalled %0d want 33/0", e, bad);
    else n_pass++;
    n_checks++;
    if (Stall !== 1'b0 || Hi !== 32'h0 || Lo !== 32'd12)
      $display("FAIL stall_done: got stall %b hi %h lo %h want 0/00000000/0000000c", Stall, Hi, Lo);
    else n_pass++;
    @(negedge Clk);
    Start = 1'b0; HiLoRead = 1'b0;
    wait_done(e, b);
    n_checks++;
    if (e !== 33 || Hi !== 32'h0 || Lo !== 32'd110)
      $display("FAIL held_start: got edges %0d hi %h lo %h want 33/00000000/0000006e", e, Hi, Lo);
    else n_pass++;
    @(negedge Clk);
  endtask

  task automatic test_flush();
    int e, b, seen;
    start_op(OP_DIVU, 32'd61, 32'd8);
    wait_done(e, b);
    n_checks++;
    if (Hi !== 32'd5 || Lo !== 32'd7) $display("FAIL flush_setup: got %h/%h want 5/7", Hi, Lo);
    else n_pass++;
    @(negedge Clk);
    start_op(OP_MULTU, 32'd123, 32'd456);
    repeat (10) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    n_checks++;
    if (Busy !== 1'b0 || Hi !== 32'd5 || Lo !== 32'd7)
      $display("FAIL flush_run: got busy %b hi %h lo %h want 0/5/7", Busy, Hi, Lo);
    else n_pass++;
    Start = 1'b1; Flush = 1'b1; Op = OP_MULTU; OpA = 32'd9; OpB = 32'd9;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    n_checks++;
    if (Busy !== 1'b0) $display("FAIL flush_idle_start: got busy %b want 0", Busy);
    else n_pass++;
    seen = 0;
    repeat (40) begin
      if (Done === 1'b1) seen++;
      @(negedge Clk);
    end
    n_checks++;
    if (seen !== 0 || Hi !== 32'd5 || Lo !== 32'd7)
      $display("FAIL flush_no_done: got done %0d hi %h lo %h want 0/5/7", seen, Hi, Lo);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    n_checks++;
    if (Busy !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0)
      $display("FAIL reset_mid: got busy %b hi %h lo %h want 0/0/0", Busy, Hi, Lo);
    else n_pass++;
    seen = 0;
    repeat (40) begin
      if (Done === 1'b1) seen++;
      @(negedge Clk);
    end
    n_checks++;
    if (seen !== 0) $display("FAIL reset_no_done: got %0d done pulses want 0", seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e, b;
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_done(e, b);
    n_checks++;
    if (e !== 33 || Hi !== 32'd2 || Lo !== 32'd14)
      $display("FAIL b2b_divu: got edges %0d hi %h lo %h want 33/2/14", e, Hi, Lo);
    else n_pass++;
    start_op(OP_MULTU, 32'd6, 32'd7);
    wait_done(e, b);
    n_checks++;
    if (e !== 33 || Hi !== 32'd0 || Lo !== 32'd42)
      $display("FAIL b2b_multu: got edges %0d hi %h lo %h want 33/0/42", e, Hi, Lo);
    else n_pass++;
    @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_divzero();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
